// File: rtl/pick_pkg.sv
// rtl/pick_pkg.sv - shared PICK helpers: tag width relation and tag extraction
package pick_pkg;

  // Tag bits needed to address flux output channels
  function automatic int unsigned tag_width(input int unsigned flux);
    return $clog2(flux);
  endfunction

  // Extract the tag that occupies the top tw bits of a width-bit token
  function automatic int unsigned tag_of(input logic [63:0] token,
                                         input int unsigned width,
                                         input int unsigned tw);
    logic [63:0] sh;
    sh = (token >> (width - tw)) & ((64'd1 << tw) - 64'd1);
    return 32'(sh);
  endfunction

endpackage

// File: rtl/tag_dispatch_if.sv
// rtl/tag_dispatch_if.sv - token input and per-flux output bundle of tag_dispatch
interface tag_dispatch_if
  import pick_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = int'(tag_width(FLUX)),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int ERR_WIDTH  = 8
);
  logic                  in_port_write;
  logic [WIDTH-1:0]      in_port_datain;
  logic                  in_port_full;
  logic [FLUX-1:0]       out_port_write;
  logic [FLUX*WIDTH-1:0] out_port_dataout;
  logic [FLUX-1:0]       out_port_full;
  logic [ERR_WIDTH-1:0]  err_count;

  // Environment side: upstream writer plus downstream PICK FIFOs
  modport master (
    output in_port_write, in_port_datain, out_port_full,
    input  in_port_full, out_port_write, out_port_dataout, err_count
  );

  // Dispatcher side
  modport slave (
    input  in_port_write, in_port_datain, out_port_full,
    output in_port_full, out_port_write, out_port_dataout, err_count
  );
endinterface

// File: rtl/tag_dispatch_fifo.sv
// rtl/tag_dispatch_fifo.sv - synchronous DEPTH x WIDTH input FIFO with visible head
module tag_dispatch_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Full decodes the registered count only; a same-cycle pop does not free a slot early
  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage array, written on accepted pushes only
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/tag_dispatch.sv
// rtl/tag_dispatch.sv - buffers a tagged token stream and routes tokens to FLUX channels
module tag_dispatch
  import pick_pkg::*;
#(
  parameter int FLUX       = 2,
  parameter int DATA_WIDTH = 8,
  parameter int TAG_WIDTH  = int'(tag_width(FLUX)),
  parameter int WIDTH      = DATA_WIDTH + TAG_WIDTH,
  parameter int DEPTH      = 4,
  parameter int ERR_WIDTH  = 8
) (
  input logic         clk,
  input logic         rst,
  tag_dispatch_if.slave bus
);
  logic [WIDTH-1:0]       head;
  logic [$clog2(DEPTH):0] count;
  logic                   full;
  logic                   empty;
  logic                   pop;
  int unsigned            tag;
  logic [FLUX-1:0]        sel;
  logic                   hit;
  logic                   dispatch;
  logic                   drop;

  logic [FLUX-1:0]        wr_q;
  logic [FLUX*WIDTH-1:0]  data_q;
  logic [ERR_WIDTH-1:0]   err_q;

  tag_dispatch_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (bus.in_port_write),
    .pop   (pop),
    .din   (bus.in_port_datain),
    .head  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  // Head decode: one-hot channel select; out-of-range tags select nothing and are dropped
  always_comb begin
    tag = tag_of(64'(head), WIDTH, TAG_WIDTH);
    sel = '0;
    for (int k = 0; k < FLUX; k++) begin
      if (tag == 32'(k)) sel[k] = 1'b1;
    end
    hit      = |sel;
    dispatch = !empty && hit && !(|(sel & bus.out_port_full));
    drop     = !empty && !hit;
    pop      = dispatch || drop;
  end

  // Registered output strobes, per-channel data holding, saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q   <= '0;
      data_q <= '0;
      err_q  <= '0;
    end else begin
      wr_q <= dispatch ? sel : '0;
      for (int k = 0; k < FLUX; k++) begin
        if (dispatch && sel[k]) data_q[k*WIDTH +: WIDTH] <= head;
      end
      if (drop && (err_q != '1)) err_q <= err_q + 1'b1;
    end
  end

  assign bus.in_port_full     = full;
  assign bus.out_port_write   = wr_q;
  assign bus.out_port_dataout = data_q;
  assign bus.err_count        = err_q;
endmodule

// File: tb/tb_tag_dispatch.sv
// tb/tb_tag_dispatch.sv - directed self-checking bench for tag_dispatch
module tb_tag_dispatch;
  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  tag_dispatch_if #(.FLUX(2), .ERR_WIDTH(8)) bus2 ();
  tag_dispatch_if #(.FLUX(3), .ERR_WIDTH(2)) bus3 ();

  tag_dispatch #(.FLUX(2), .ERR_WIDTH(8)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  tag_dispatch #(.FLUX(3), .ERR_WIDTH(2)) dut3 (.clk(clk), .rst(rst), .bus(bus3));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", name, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus2.in_port_write = 1'b0; bus2.in_port_datain = '0; bus2.out_port_full = '0;
    bus3.in_port_write = 1'b0; bus3.in_port_datain = '0; bus3.out_port_full = '0;
    tick; tick;
    check("rst_in_full",  64'(bus2.in_port_full), 64'd0);
    check("rst_out_wr",   64'(bus2.out_port_write), 64'd0);
    check("rst_out_data", 64'(bus2.out_port_dataout), 64'd0);
    check("rst_err2",     64'(bus2.err_count), 64'd0);
    check("rst_err3",     64'(bus3.err_count), 64'd0);
    rst = 1'b0;

    // single token, two-cycle latency
    bus2.in_port_write = 1'b1; bus2.in_port_datain = 9'h0A5;
    tick;
    bus2.in_port_write = 1'b0;
    check("single_lat1_wr", 64'(bus2.out_port_write), 64'd0);
    tick;
    check("single_wr",   64'(bus2.out_port_write), 64'h1);
    check("single_data", 64'(bus2.out_port_dataout[8:0]), 64'h0A5);
    check("single_err",  64'(bus2.err_count), 64'd0);
    tick;
    check("single_idle", 64'(bus2.out_port_write), 64'd0);

    // back-to-back alternating tags
    bus2.in_port_write = 1'b1; bus2.in_port_datain = 9'h011;
    tick;
    bus2.in_port_datain = 9'h122;
    tick;
    check("b2b0_wr", 64'(bus2.out_port_write), 64'h1);
    check("b2b0_d",  64'(bus2.out_port_dataout[8:0]), 64'h011);
    bus2.in_port_datain = 9'h033;
    tick;
    check("b2b1_wr", 64'(bus2.out_port_write), 64'h2);
    check("b2b1_d",  64'(bus2.out_port_dataout[17:9]), 64'h122);
    bus2.in_port_datain = 9'h144;
    tick;
    check("b2b2_wr", 64'(bus2.out_port_write), 64'h1);
    check("b2b2_d",  64'(bus2.out_port_dataout[8:0]), 64'h033);
    bus2.in_port_write = 1'b0;
    tick;
    check("b2b3_wr", 64'(bus2.out_port_write), 64'h2);
    check("b2b3_d",  64'(bus2.out_port_dataout[17:9]), 64'h144);
    check("b2b_hold_ch0", 64'(bus2.out_port_dataout[8:0]), 64'h033);
    tick;
    check("b2b_idle", 64'(bus2.out_port_write), 64'd0);

    // head-of-line stall on channel 1
    bus2.out_port_full = 2'b10;
    bus2.in_port_write = 1'b1; bus2.in_port_datain = 9'h155;
    tick;
    check("stall_wr0", 64'(bus2.out_port_write), 64'd0);
    bus2.in_port_datain = 9'h066;
    tick;
    check("stall_wr1", 64'(bus2.out_port_write), 64'd0);
    bus2.in_port_datain = 9'h077;
    tick;
    check("stall_wr2", 64'(bus2.out_port_write), 64'd0);
    check("stall_notfull", 64'(bus2.in_port_full), 64'd0);
    bus2.in_port_datain = 9'h088;
    tick;
    check("stall_wr3", 64'(bus2.out_port_write), 64'd0);
    check("stall_full", 64'(bus2.in_port_full), 64'd1);
    bus2.in_port_write = 1'b0;
    bus2.out_port_full = 2'b00;
    tick;
    check("rel0_wr", 64'(bus2.out_port_write), 64'h2);
    check("rel0_d",  64'(bus2.out_port_dataout[17:9]), 64'h155);
    check("rel0_full", 64'(bus2.in_port_full), 64'd0);
    tick;
    check("rel1_wr", 64'(bus2.out_port_write), 64'h1);
    check("rel1_d",  64'(bus2.out_port_dataout[8:0]), 64'h066);
    tick;
    check("rel2_d",  64'(bus2.out_port_dataout[8:0]), 64'h077);
    tick;
    check("rel3_d",  64'(bus2.out_port_dataout[8:0]), 64'h088);
    tick;
    check("rel_idle", 64'(bus2.out_port_write), 64'd0);

    // overflow: writes while full are ignored
    bus2.out_port_full = 2'b11;
    bus2.in_port_write = 1'b1;
    bus2.in_port_datain = 9'h0B1; tick;
    bus2.in_port_datain = 9'h1B2; tick;
    bus2.in_port_datain = 9'h0B3; tick;
    bus2.in_port_datain = 9'h1B4; tick;
    bus2.in_port_datain = 9'h1FF; tick;
    tick;
    check("ovf_full", 64'(bus2.in_port_full), 64'd1);
    check("ovf_wr",   64'(bus2.out_port_write), 64'd0);
    bus2.in_port_write = 1'b0;
    bus2.out_port_full = 2'b00;
    tick;
    check("drain0_wr", 64'(bus2.out_port_write), 64'h1);
    check("drain0_d",  64'(bus2.out_port_dataout[8:0]), 64'h0B1);
    tick;
    check("drain1_wr", 64'(bus2.out_port_write), 64'h2);
    check("drain1_d",  64'(bus2.out_port_dataout[17:9]), 64'h1B2);
    tick;
    check("drain2_d",  64'(bus2.out_port_dataout[8:0]), 64'h0B3);
    tick;
    check("drain3_wr", 64'(bus2.out_port_write), 64'h2);
    check("drain3_d",  64'(bus2.out_port_dataout[17:9]), 64'h1B4);
    tick;
    check("drain_end0", 64'(bus2.out_port_write), 64'd0);
    tick;
    check("drain_end1", 64'(bus2.out_port_write), 64'd0);
    check("drain_ch1_hold", 64'(bus2.out_port_dataout[17:9]), 64'h1B4);

    // FLUX=3: out-of-range tag dropped, counter saturates at 3
    bus3.in_port_write = 1'b1; bus3.in_port_datain = 10'h3AA;
    tick;
    bus3.in_port_write = 1'b0;
    tick;
    check("drop_wr",  64'(bus3.out_port_write), 64'd0);
    check("drop_err", 64'(bus3.err_count), 64'd1);
    bus3.in_port_write = 1'b1;
    tick; tick; tick; tick;
    bus3.in_port_write = 1'b0;
    tick; tick;
    check("drop_sat", 64'(bus3.err_count), 64'd3);
    check("drop_sat_wr", 64'(bus3.out_port_write), 64'd0);
    bus3.in_port_write = 1'b1; bus3.in_port_datain = 10'h2C3;
    tick;
    bus3.in_port_write = 1'b0;
    tick;
    check("ch2_wr", 64'(bus3.out_port_write), 64'h4);
    check("ch2_d",  64'(bus3.out_port_dataout[29:20]), 64'h2C3);
    check("ch2_err", 64'(bus3.err_count), 64'd3);

    // reset mid-stream with buffered tokens and a pending write
    bus2.out_port_full = 2'b11;
    bus2.in_port_write = 1'b1;
    bus2.in_port_datain = 9'h0D1; tick;
    bus2.in_port_datain = 9'h0D2; tick;
    bus2.in_port_datain = 9'h0D3; tick;
    bus2.in_port_datain = 9'h0D4;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    bus2.in_port_write = 1'b0;
    check("mrst_full", 64'(bus2.in_port_full), 64'd0);
    check("mrst_wr",   64'(bus2.out_port_write), 64'd0);
    check("mrst_data", 64'(bus2.out_port_dataout), 64'd0);
    check("mrst_err3", 64'(bus3.err_count), 64'd0);
    bus2.out_port_full = 2'b00;
    tick;
    check("mrst_stale0", 64'(bus2.out_port_write), 64'd0);
    tick;
    check("mrst_stale1", 64'(bus2.out_port_write), 64'd0);
    tick;
    check("mrst_stale2", 64'(bus2.out_port_write), 64'd0);
    bus2.in_port_write = 1'b1; bus2.in_port_datain = 9'h1E1;
    tick;
    bus2.in_port_write = 1'b0;
    tick;
    check("post_rst_wr", 64'(bus2.out_port_write), 64'h2);
    check("post_rst_d",  64'(bus2.out_port_dataout[17:9]), 64'h1E1);
    tick;
    check("post_rst_idle", 64'(bus2.out_port_write), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
